// File: rtl/switch_toggle_bank_if.sv
// Switch/LED bundle for switch_toggle_bank: raw switch levels and clear in,
// per-channel toggle state, edge pulses and debounced level out.
interface switch_toggle_bank_if #(
    parameter int unsigned NUM_CH = 4
);
    logic              i_Clear;
    logic [NUM_CH-1:0] i_Switch;
    logic [NUM_CH-1:0] o_LED;
    logic [NUM_CH-1:0] o_Edge;
    logic [NUM_CH-1:0] o_State;

    modport master (
        output i_Clear,
        output i_Switch,
        input  o_LED,
        input  o_Edge,
        input  o_State
    );

    modport slave (
        input  i_Clear,
        input  i_Switch,
        output o_LED,
        output o_Edge,
        output o_State
    );
endinterface

// File: rtl/switch_toggle_bank.sv
// Multi-channel switch toggler: two-flop synchroniser, counting debouncer and
// edge qualifier per channel; each qualifying accept flips that channel's LED.
module switch_toggle_bank #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned DEBOUNCE_LIMIT = 250000,
    parameter int unsigned EDGE_MODE      = 0
) (
    input logic                 i_Clk,
    input logic                 i_Reset,
    switch_toggle_bank_if.slave bus_io
);

    localparam int unsigned CntW = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_LIMIT - 1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    logic [NUM_CH-1:0]           sync1_q, sync2_q;
    logic [NUM_CH-1:0][CntW-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0]           stable_q, stable_d;
    logic [NUM_CH-1:0]           led_q, led_d;
    logic [NUM_CH-1:0]           edge_q, edge_d;

    // Which direction of a newly accepted level counts as an edge.
    function automatic logic qualifies(input logic new_lvl);
        if (EDGE_MODE == 0) begin
            return ~new_lvl;
        end else if (EDGE_MODE == 1) begin
            return new_lvl;
        end else begin
            return 1'b1;
        end
    endfunction

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        led_d    = led_q;
        edge_d   = '0;
        for (int ch = 0; ch < int'(NUM_CH); ch++) begin
            if (sync2_q[ch] == stable_q[ch]) begin
                cnt_d[ch] = '0;
            end else if (cnt_q[ch] == CntMax) begin
                stable_d[ch] = sync2_q[ch];
                cnt_d[ch]    = '0;
                if (qualifies(sync2_q[ch])) begin
                    led_d[ch]  = ~led_q[ch];
                    edge_d[ch] = 1'b1;
                end
            end else begin
                cnt_d[ch] = cnt_q[ch] + CntOne;
            end
        end
        // Clear overrides any toggle this cycle; edge and debounce state still advance.
        if (bus_io.i_Clear) begin
            led_d = '0;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
            led_q    <= '0;
            edge_q   <= '0;
        end else begin
            sync1_q  <= bus_io.i_Switch;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            led_q    <= led_d;
            edge_q   <= edge_d;
        end
    end

    assign bus_io.o_LED   = led_q;
    assign bus_io.o_Edge  = edge_q;
    assign bus_io.o_State = stable_q;

endmodule

// File: tb/tb_switch_toggle_bank.sv
// Directed bench: three instances (falling, rising, both-edge modes) driven by
// the same switches and clear, checked against hand-computed values.
module tb_switch_toggle_bank;

    logic       clk;
    logic       rst;
    logic       clr;
    logic [1:0] sw;
    int         n_cmp;
    int         n_err;

    switch_toggle_bank_if #(.NUM_CH(2)) bus0 ();
    switch_toggle_bank_if #(.NUM_CH(2)) bus1 ();
    switch_toggle_bank_if #(.NUM_CH(2)) bus2 ();

    assign bus0.i_Switch = sw;
    assign bus1.i_Switch = sw;
    assign bus2.i_Switch = sw;
    assign bus0.i_Clear  = clr;
    assign bus1.i_Clear  = clr;
    assign bus2.i_Clear  = clr;

    switch_toggle_bank #(.NUM_CH(2), .DEBOUNCE_LIMIT(4), .EDGE_MODE(0)) dut0 (
        .i_Clk   (clk),
        .i_Reset (rst),
        .bus_io  (bus0.slave)
    );
    switch_toggle_bank #(.NUM_CH(2), .DEBOUNCE_LIMIT(4), .EDGE_MODE(1)) dut1 (
        .i_Clk   (clk),
        .i_Reset (rst),
        .bus_io  (bus1.slave)
    );
    switch_toggle_bank #(.NUM_CH(2), .DEBOUNCE_LIMIT(4), .EDGE_MODE(2)) dut2 (
        .i_Clk   (clk),
        .i_Reset (rst),
        .bus_io  (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // Check LED, edge and state of one instance (m = edge mode).
    task automatic chk_m(input string tag, input int m, input logic [1:0] led,
                         input logic [1:0] edg, input logic [1:0] st);
        logic [1:0] g_led, g_edg, g_st;
        case (m)
            0:       begin g_led = bus0.o_LED; g_edg = bus0.o_Edge; g_st = bus0.o_State; end
            1:       begin g_led = bus1.o_LED; g_edg = bus1.o_Edge; g_st = bus1.o_State; end
            default: begin g_led = bus2.o_LED; g_edg = bus2.o_Edge; g_st = bus2.o_State; end
        endcase
        chk($sformatf("%s m%0d led", tag, m), g_led, led);
        chk($sformatf("%s m%0d edge", tag, m), g_edg, edg);
        chk($sformatf("%s m%0d state", tag, m), g_st, st);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        clr   = 1'b0;
        sw    = 2'b00;

        // Reset values
        ticks(3);
        rst = 1'b0;
        ticks(1);
        chk_m("reset", 0, 2'b00, 2'b00, 2'b00);
        chk_m("reset", 1, 2'b00, 2'b00, 2'b00);
        chk_m("reset", 2, 2'b00, 2'b00, 2'b00);

        // Clean press of ch0: accept 5 edges after capture
        sw = 2'b01;
        ticks(5);
        chk_m("press_pre", 0, 2'b00, 2'b00, 2'b00);
        ticks(1);
        chk_m("press_acc", 0, 2'b00, 2'b00, 2'b01);
        chk_m("press_acc", 1, 2'b01, 2'b01, 2'b01);
        chk_m("press_acc", 2, 2'b01, 2'b01, 2'b01);
        ticks(1);
        chk_m("press_post", 1, 2'b01, 2'b00, 2'b01);
        ticks(3);

        // Clean release of ch0
        sw = 2'b00;
        ticks(5);
        chk_m("rel_pre", 0, 2'b00, 2'b00, 2'b01);
        ticks(1);
        chk_m("rel_acc", 0, 2'b01, 2'b01, 2'b00);
        chk_m("rel_acc", 1, 2'b01, 2'b00, 2'b00);
        chk_m("rel_acc", 2, 2'b00, 2'b01, 2'b00);
        ticks(1);
        chk_m("rel_post", 0, 2'b01, 2'b00, 2'b00);

        // Bounce 1,0,1,0,1 at one-cycle spacing, then hold high
        sw = 2'b01; ticks(1);
        sw = 2'b00; ticks(1);
        sw = 2'b01; ticks(1);
        sw = 2'b00; ticks(1);
        sw = 2'b01;
        ticks(5);
        chk_m("bounce_pre", 0, 2'b01, 2'b00, 2'b00);
        chk_m("bounce_pre", 1, 2'b01, 2'b00, 2'b00);
        ticks(1);
        chk_m("bounce_acc", 0, 2'b01, 2'b00, 2'b01);
        chk_m("bounce_acc", 1, 2'b00, 2'b01, 2'b01);
        chk_m("bounce_acc", 2, 2'b01, 2'b01, 2'b01);

        // Release ch0 so every instance returns to LED 00
        sw = 2'b00;
        ticks(6);
        chk_m("norm", 0, 2'b00, 2'b01, 2'b00);
        chk_m("norm", 1, 2'b00, 2'b00, 2'b00);
        chk_m("norm", 2, 2'b00, 2'b01, 2'b00);

        // Both channels together
        sw = 2'b11;
        ticks(6);
        chk_m("multi_press", 2, 2'b11, 2'b11, 2'b11);
        chk_m("multi_press", 0, 2'b00, 2'b00, 2'b11);
        ticks(1);
        chk_m("multi_gap", 2, 2'b11, 2'b00, 2'b11);
        sw = 2'b00;
        ticks(6);
        chk_m("multi_rel", 2, 2'b00, 2'b11, 2'b00);
        chk_m("multi_rel", 0, 2'b11, 2'b11, 2'b00);
        chk_m("multi_rel", 1, 2'b11, 2'b00, 2'b00);

        // Clear on the exact accept edge of a ch0 release
        sw = 2'b01;
        ticks(6);
        chk_m("clr_press", 2, 2'b01, 2'b01, 2'b01);
        sw = 2'b00;
        ticks(5);
        clr = 1'b1;
        ticks(1);
        clr = 1'b0;
        chk_m("clr_acc", 0, 2'b00, 2'b01, 2'b00);
        chk_m("clr_acc", 1, 2'b00, 2'b00, 2'b00);
        chk_m("clr_acc", 2, 2'b00, 2'b01, 2'b00);
        sw = 2'b01;
        ticks(6);
        sw = 2'b00;
        ticks(6);
        chk_m("clr_later", 0, 2'b01, 2'b01, 2'b00);

        // Reset mid-debounce, asserted asynchronously between edges
        sw = 2'b01;
        ticks(3);
        rst = 1'b1;
        #1;
        chk("async_rst led", bus0.o_LED, 2'b00);
        sw = 2'b00;
        ticks(2);
        rst = 1'b0;
        ticks(8);
        chk_m("mid_rst", 0, 2'b00, 2'b00, 2'b00);
        chk_m("mid_rst", 1, 2'b00, 2'b00, 2'b00);

        // Switch held high across reset release
        rst = 1'b1;
        sw  = 2'b01;
        ticks(3);
        rst = 1'b0;
        ticks(5);
        chk_m("held_pre", 1, 2'b00, 2'b00, 2'b00);
        ticks(1);
        chk_m("held_acc", 1, 2'b01, 2'b01, 2'b01);
        chk_m("held_acc", 0, 2'b00, 2'b00, 2'b01);
        chk_m("held_acc", 2, 2'b01, 2'b01, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/switch_toggle_bank.md
# switch_toggle_bank

Multi-channel debounced switch toggler: each of NUM_CH mechanical switch inputs is synchronised, debounced, and edge-detected. Each qualifying edge toggles a per-channel LED register and emits a one-cycle edge pulse. It sits between the raw board switch pins and LED/user logic. It replaces single-channel, undebounced toggle logic with a configurable edge mode and a synchronous clear.

## Interface

- NUM_CH, 4, number of independent switch/LED channels (≥1)
- DEBOUNCE_LIMIT, 250000, consecutive cycles a new synchronised level must persist before it is accepted (≥1); counter width is max(1, $clog2(DEBOUNCE_LIMIT))
- EDGE_MODE, 0, qualifying edge of the debounced level: 0 = falling (release), 1 = rising (press), 2 = both
- i_Clk  in  1  system clock
- i_Reset  in  1  asynchronous, active-high reset
- i_Clear  in  1  synchronous clear of all toggle registers
- i_Switch  in  NUM_CH  raw asynchronous switch levels, one per channel
- o_LED  out  NUM_CH  per-channel toggle state
- o_Edge  out  NUM_CH  one-cycle pulse per qualifying debounced edge
- o_State  out  NUM_CH  debounced switch level

## Operation

- Reset (asynchronous, active-high): clears every register in the block, with all outputs at 0.
  - Registers: sync stages, debounce counters, stable levels, toggle registers, edge pulses.
- Channels are fully independent; no shared state except i_Clear.
- Per-channel pipeline:
  - **Synchroniser:** two flops, r_Sync1 ← i_Switch[n], r_Sync2 ← r_Sync1.
  - **Debounce.** Each edge:
    - if r_Sync2 == r_Stable: counter ← 0;
    - else if counter == DEBOUNCE_LIMIT−1: r_Stable ← r_Sync2, counter ← 0 (the "accept" event);
    - else counter ← counter+1.
    - Any return to the stable level before accept restarts the count from 0.
  - **Qualify:** an accept is qualifying when:
    - EDGE_MODE 0: new level is 0;
    - EDGE_MODE 1: new level is 1;
    - EDGE_MODE 2: always.
  - **Toggle:** on a qualifying accept, o_LED[n] inverts and o_Edge[n] is 1 for exactly that following cycle. Otherwise o_Edge[n] is 0.
- i_Clear: every o_LED bit ← 0 at that edge.
  - Clear wins over a simultaneous qualifying accept: o_LED stays 0, but o_Edge still pulses and o_State still updates.
  - Debounce state is unaffected.
- o_State[n] = r_Stable; o_LED[n] = toggle register; o_Edge[n] = registered pulse. All outputs are registered, with no combinational path from inputs.
- Switch held high through reset release: r_Stable starts at 0, so the high level is accepted after the debounce latency as a rising edge.
  - EDGE_MODE 1/2 toggle on it; EDGE_MODE 0 does not.
- Reset mid-debounce discards the partial count; the count restarts after reset release.

## Timing

- Input level first captured by r_Sync1 at edge k and held thereafter: accept occurs at edge k+1+DEBOUNCE_LIMIT. o_State, o_LED and o_Edge all change at that same edge.
- DEBOUNCE_LIMIT=1: accept at edge k+2 (synchroniser latency only).
- Pulses shorter than DEBOUNCE_LIMIT cycles at r_Sync2 produce no output change.
- Minimum spacing between consecutive accepts on a channel is DEBOUNCE_LIMIT cycles, so o_Edge pulses on one channel are never adjacent when DEBOUNCE_LIMIT ≥ 2.
- Counter never exceeds DEBOUNCE_LIMIT−1; no wrap.
- Throughput: one accept per channel per DEBOUNCE_LIMIT cycles; all channels may accept in the same cycle.

## Test plan

- **Reset values.** NUM_CH=2, DEBOUNCE_LIMIT=4, EDGE_MODE=0, i_Switch=0. Assert i_Reset for 3 cycles then release → o_LED=00, o_Edge=00, o_State=00. Asserting i_Reset asynchronously mid-cycle zeroes the outputs before the next clock edge.
- **Clean press/release, mode 0.** Ch0 rises at edge k and is held 10 cycles, then falls and is held.
  - o_State[0]=1 at edge k+5, with o_LED unchanged and no o_Edge.
  - On the fall, o_State[0]=0, o_LED[0]=1 and o_Edge[0]=1 for one cycle, 5 edges after the fall is captured.
  - Ch1 stays 00.
- **Bounce rejection.** LIMIT=4. Ch0 toggles 1,0,1,0,1 at 1-cycle intervals, then holds 1.
  - o_State[0] goes to 1 exactly 5 edges after the final rise is captured.
  - Exactly one transition; zero edges in mode 0; one edge in mode 1.
- **Mode 2 and multi-channel.** Both channels press and release simultaneously → o_Edge=11 pulses twice, and o_LED goes 00→11→00.
- **Clear collision.** Assert i_Clear on the exact accept edge of a qualifying release with o_LED[0]=1 → o_LED[0]=0 and o_Edge[0]=1. On a later release, o_LED[0]=1.
- **Reset mid-debounce / held through reset.**
  - Reset asserted 2 cycles into a 4-cycle debounce → no output change.
  - Switch held 1 across reset release, mode 1 → o_LED[0]=1 and o_Edge pulse at edge 5 after release capture.
  - Same case in mode 0 → o_LED stays 0.
